// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: default row geometry, SRAM depth and FSM state type.
package weight_loader_pkg;

   localparam int unsigned K_CHANNELS = 8;
   localparam int unsigned INT_WIDTH  = 8;
   localparam int unsigned SRAM_DEPTH = 512;

   typedef enum logic [1:0] {IDLE, LOAD, FINISH} wl_state_e;

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_loader_row_packer.sv
// Packs consecutive weights into one SRAM row (lane 0 = first weight). Row-complete fires on the
// last lane or on the job's final word; unfilled lanes stay zero because the pack register clears per row.
module weight_row_packer #(
   parameter int unsigned K_CHANNELS = weight_loader_pkg::K_CHANNELS,
   parameter int unsigned INT_WIDTH  = weight_loader_pkg::INT_WIDTH
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            clear_i,
   input  logic                            push_i,
   input  logic                            last_i,
   input  logic [INT_WIDTH-1:0]            data_i,
   output logic [K_CHANNELS*INT_WIDTH-1:0] row_o,
   output logic                            row_done_o
);
   import weight_loader_pkg::*;

   localparam int unsigned LANE_W = cnt_bits(K_CHANNELS);

   logic [LANE_W-1:0]               lane_q, lane_d;
   logic [K_CHANNELS*INT_WIDTH-1:0] pack_q, pack_d;

   always_comb begin
      row_o = pack_q;
      row_o[lane_q*INT_WIDTH +: INT_WIDTH] = data_i;
      row_done_o = push_i && (last_i || (lane_q == LANE_W'(K_CHANNELS - 1)));
   end

   always_comb begin
      pack_d = pack_q;
      lane_d = lane_q;
      if (clear_i || row_done_o) begin
         pack_d = '0;
         lane_d = '0;
      end else if (push_i) begin
         pack_d = row_o;
         lane_d = lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pack_q <= '0;
         lane_q <= '0;
      end else begin
         pack_q <= pack_d;
         lane_q <= lane_d;
      end
   end

endmodule

// File: rtl/weight_loader.sv
// Weight-buffer loader: packs a valid/ready weight stream into rows and writes them to consecutive
// SRAM addresses with modulo-DEPTH wrap. Define WEIGHT_LOADER_CKSUM_EN to add the cksum_o port.
module weight_loader #(
   parameter  int unsigned K_CHANNELS = weight_loader_pkg::K_CHANNELS,
   parameter  int unsigned INT_WIDTH  = weight_loader_pkg::INT_WIDTH,
   parameter  int unsigned DEPTH      = weight_loader_pkg::SRAM_DEPTH,
   localparam int unsigned ADDR_W     = $clog2(DEPTH),
   localparam int unsigned CNT_W      = $clog2(DEPTH*K_CHANNELS+1)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [ADDR_W-1:0]               cfg_base_addr_i,
   input  logic [CNT_W-1:0]                cfg_num_words_i,
   output logic                            busy_o,
   output logic                            done_o,
   input  logic                            s_valid_i,
   input  logic [INT_WIDTH-1:0]            s_data_i,
   output logic                            s_ready_o,
   output logic                            wr_en_o,
   output logic [ADDR_W-1:0]               wr_addr_o,
   output logic [K_CHANNELS*INT_WIDTH-1:0] wr_data_o,
   output logic [ADDR_W:0]                 rows_written_o
`ifdef WEIGHT_LOADER_CKSUM_EN
  ,output logic [31:0]                     cksum_o
`endif
);
   import weight_loader_pkg::*;

   wl_state_e state_q, state_d;

   logic                            busy, ready, done_d, done_q;
   logic                            accept, xfer, last_word, row_done;
   logic [ADDR_W-1:0]               cur_addr_q, cur_addr_d, wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0]                words_left_q, words_left_d;
   logic [ADDR_W:0]                 rows_q, rows_d;
   logic                            wr_en_q, wr_en_d;
   logic [K_CHANNELS*INT_WIDTH-1:0] wr_data_q, wr_data_d, row;

   assign accept    = start_i && (state_q == IDLE);
   assign xfer      = s_valid_i && ready;
   assign last_word = (words_left_q == CNT_W'(1));

   weight_row_packer #(
      .K_CHANNELS (K_CHANNELS),
      .INT_WIDTH  (INT_WIDTH)
   ) u_packer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (accept),
      .push_i     (xfer),
      .last_i     (last_word),
      .data_i     (s_data_i),
      .row_o      (row),
      .row_done_o (row_done)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = (cfg_num_words_i == '0) ? FINISH : LOAD;
         LOAD:    if (xfer && last_word) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // done is registered off FINISH so it lands the cycle after the final row write.
   always_comb begin
      busy   = 1'b0;
      ready  = 1'b0;
      done_d = 1'b0;
      unique case (state_q)
         LOAD: begin
            busy  = 1'b1;
            ready = 1'b1;
         end
         FINISH: begin
            busy   = 1'b1;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      cur_addr_d   = cur_addr_q;
      words_left_d = words_left_q;
      rows_d       = rows_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_en_d      = row_done;
      if (wr_en_q) rows_d = rows_q + 1'b1;
      if (accept) begin
         cur_addr_d   = cfg_base_addr_i;
         words_left_d = cfg_num_words_i;
         rows_d       = '0;
      end
      if (xfer) words_left_d = words_left_q - 1'b1;
      if (row_done) begin
         wr_addr_d  = cur_addr_q;
         wr_data_d  = row;
         cur_addr_d = (cur_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur_addr_q   <= '0;
         words_left_q <= '0;
         rows_q       <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_en_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         cur_addr_q   <= cur_addr_d;
         words_left_q <= words_left_d;
         rows_q       <= rows_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_en_q      <= wr_en_d;
         done_q       <= done_d;
      end
   end

`ifdef WEIGHT_LOADER_CKSUM_EN
   logic [31:0] cksum_q, cksum_d;

   always_comb begin
      cksum_d = cksum_q;
      if (accept)    cksum_d = '0;
      else if (xfer) cksum_d = cksum_q + 32'(signed'(s_data_i));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cksum_q <= '0;
      else       cksum_q <= cksum_d;
   end

   assign cksum_o = cksum_q;
`endif

   assign busy_o         = busy;
   assign s_ready_o      = ready;
   assign done_o         = done_q;
   assign wr_en_o        = wr_en_q;
   assign wr_addr_o      = wr_addr_q;
   assign wr_data_o      = wr_data_q;
   assign rows_written_o = rows_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader (K=4, 8-bit weights, 16 rows); covers cksum_o when
// WEIGHT_LOADER_CKSUM_EN is defined.
module tb_weight_loader;

   localparam int unsigned K  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned D  = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned CW = 7;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic [AW-1:0] cfg_base_addr_i = '0;
   logic [CW-1:0] cfg_num_words_i = '0;
   logic          busy_o, done_o;
   logic          s_valid_i = 1'b0;
   logic [W-1:0]  s_data_i = '0;
   logic          s_ready_o, wr_en_o;
   logic [AW-1:0] wr_addr_o;
   logic [K*W-1:0] wr_data_o;
   logic [AW:0]   rows_written_o;
`ifdef WEIGHT_LOADER_CKSUM_EN
   logic [31:0]   cksum_o;
`endif

   weight_loader #(
      .K_CHANNELS (K),
      .INT_WIDTH  (W),
      .DEPTH      (D)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .cfg_base_addr_i (cfg_base_addr_i),
      .cfg_num_words_i (cfg_num_words_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .s_valid_i       (s_valid_i),
      .s_data_i        (s_data_i),
      .s_ready_o       (s_ready_o),
      .wr_en_o         (wr_en_o),
      .wr_addr_o       (wr_addr_o),
      .wr_data_o       (wr_data_o),
      .rows_written_o  (rows_written_o)
`ifdef WEIGHT_LOADER_CKSUM_EN
     ,.cksum_o         (cksum_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Write/done monitor, sampled on the falling edge.
   logic [AW-1:0]  wq_addr[$];
   logic [K*W-1:0] wq_data[$];
   int last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;
   always @(negedge clk_i) begin
      if (wr_en_o) begin
         wq_addr.push_back(wr_addr_o);
         wq_data.push_back(wr_data_o);
         last_wr_cyc = cyc;
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk_i);
      #1;
   endtask

   logic [W-1:0] stim[16];
   int start_cyc;
   int ready_drops;
   logic ready_after;

   task automatic run_job(input logic [AW-1:0] base, input logic [CW-1:0] num,
                          input bit gaps, input bit mid);
      int sent = 0;
      int k = 0;
      logic rdy;
      wq_addr.delete();
      wq_data.delete();
      done_cnt = 0;
      ready_drops = 0;
      start_i = 1'b1;
      cfg_base_addr_i = base;
      cfg_num_words_i = num;
      start_cyc = cyc;
      tick;
      start_i = 1'b0;
      cfg_base_addr_i = '0;
      cfg_num_words_i = '0;
      while (sent < int'(num) && k < 200) begin
         s_valid_i = !gaps || (k % 3 == 0);
         s_data_i  = stim[sent];
         if (mid && k == 1) begin
            start_i = 1'b1;
            cfg_base_addr_i = 4'd9;
            cfg_num_words_i = 7'd1;
         end else begin
            start_i = 1'b0;
         end
         rdy = s_ready_o;
         if (!rdy) ready_drops++;
         tick;
         if (s_valid_i && rdy) sent++;
         k++;
      end
      s_valid_i = 1'b0;
      start_i = 1'b0;
      ready_after = s_ready_o;
      for (int i = 0; i < 20 && done_cnt == 0; i++) tick;
      tick;
      tick;
   endtask

   typedef struct {
      logic [AW-1:0]  base;
      logic [CW-1:0]  num;
      bit             gaps;
      bit             mid;
      int             nwr;
      logic [AW-1:0]  a0, a1;
      logic [K*W-1:0] d0, d1;
      logic [AW:0]    rows;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{4'd0,  7'd8, 1'b0, 1'b0, 2, 4'd0,  4'd1,  32'h04030201, 32'h08070605, 5'd2};
      vt[1] = '{4'd3,  7'd6, 1'b0, 1'b1, 2, 4'd3,  4'd4,  32'h04030201, 32'h00000605, 5'd2};
      vt[2] = '{4'd15, 7'd8, 1'b0, 1'b0, 2, 4'd15, 4'd0,  32'h04030201, 32'h08070605, 5'd2};
      vt[3] = '{4'd7,  7'd4, 1'b1, 1'b0, 1, 4'd7,  4'd0,  32'h04030201, 32'h00000000, 5'd1};
      vt[4] = '{4'd4,  7'd0, 1'b0, 1'b0, 0, 4'd0,  4'd0,  32'h00000000, 32'h00000000, 5'd0};
      vt[5] = '{4'd9,  7'd5, 1'b1, 1'b0, 2, 4'd9,  4'd10, 32'h04030201, 32'h00000005, 5'd2};
      for (int i = 0; i < 16; i++) stim[i] = W'(i + 1);

      repeat (3) tick;
      rst_i = 1'b0;
      tick;
      chk("reset_busy",  busy_o, 0);
      chk("reset_done",  done_o, 0);
      chk("reset_ready", s_ready_o, 0);
      chk("reset_wr_en", wr_en_o, 0);
      chk("reset_rows",  rows_written_o, 0);
      chk("reset_wdata", wr_data_o, 0);

      for (int v = 0; v < 6; v++) begin
         run_job(vt[v].base, vt[v].num, vt[v].gaps, vt[v].mid);
         chk($sformatf("v%0d_nwrites", v), wq_addr.size(), vt[v].nwr);
         if (vt[v].nwr > 0) begin
            chk($sformatf("v%0d_addr0", v), (wq_addr.size() > 0) ? wq_addr[0] : 'x, vt[v].a0);
            chk($sformatf("v%0d_data0", v), (wq_data.size() > 0) ? wq_data[0] : 'x, vt[v].d0);
         end
         if (vt[v].nwr > 1) begin
            chk($sformatf("v%0d_addr1", v), (wq_addr.size() > 1) ? wq_addr[1] : 'x, vt[v].a1);
            chk($sformatf("v%0d_data1", v), (wq_data.size() > 1) ? wq_data[1] : 'x, vt[v].d1);
         end
         chk($sformatf("v%0d_rows", v), rows_written_o, vt[v].rows);
         chk($sformatf("v%0d_done_count", v), done_cnt, 1);
         chk($sformatf("v%0d_done_cycle", v), done_cyc,
             (vt[v].nwr > 0) ? last_wr_cyc + 1 : start_cyc + 2);
         chk($sformatf("v%0d_ready_drops", v), ready_drops, 0);
         chk($sformatf("v%0d_ready_after_last", v), ready_after, 0);
         chk($sformatf("v%0d_idle", v), busy_o, 0);
`ifdef WEIGHT_LOADER_CKSUM_EN
         chk($sformatf("v%0d_cksum", v), cksum_o, (int'(vt[v].num) * (int'(vt[v].num) + 1)) / 2);
`endif
      end

      // Reset after two of four lanes: partial row must be dropped.
      wq_addr.delete();
      wq_data.delete();
      start_i = 1'b1;
      cfg_base_addr_i = 4'd2;
      cfg_num_words_i = 7'd4;
      tick;
      start_i = 1'b0;
      s_valid_i = 1'b1;
      s_data_i = 8'h11;
      tick;
      s_data_i = 8'h22;
      tick;
      s_valid_i = 1'b0;
      rst_i = 1'b1;
      tick;
      rst_i = 1'b0;
      tick;
      chk("rst_mid_nwrites", wq_addr.size(), 0);
      chk("rst_mid_busy",    busy_o, 0);
      chk("rst_mid_ready",   s_ready_o, 0);
      chk("rst_mid_wr_addr", wr_addr_o, 0);
      chk("rst_mid_wr_data", wr_data_o, 0);
      chk("rst_mid_rows",    rows_written_o, 0);

      stim[0] = 8'hFF;
      stim[1] = 8'h02;
      stim[2] = 8'h03;
      stim[3] = 8'h04;
      run_job(4'd5, 7'd4, 1'b0, 1'b0);
      chk("post_rst_nwrites", wq_addr.size(), 1);
      chk("post_rst_addr", (wq_addr.size() > 0) ? wq_addr[0] : 'x, 4'd5);
      chk("post_rst_data", (wq_data.size() > 0) ? wq_data[0] : 'x, 32'h040302FF);
      chk("post_rst_rows", rows_written_o, 1);
`ifdef WEIGHT_LOADER_CKSUM_EN
      chk("post_rst_cksum", cksum_o, 8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
